// File: rtl/grf_mp_pkg.sv
// Shared definitions for the multi-port register file grf_mp.
// Holds default widths, the hard-wired zero register index and the pending-counter helpers.
package grf_mp_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int CNT_W_DEF  = 2;
  localparam int ZERO_REG   = 0;

  typedef logic [CNT_W_DEF-1:0] pcnt_t;
  typedef logic signed [2:0]    delta_t;

  // Net counter change: +1 for an accepted issue, -1 per matching write.
  function automatic delta_t net_delta(input logic inc, input logic [1:0] wr_matches);
    return $signed({2'b00, inc}) - $signed({1'b0, wr_matches});
  endfunction

endpackage

// File: rtl/grf_bypass_mux.sv
// One read port of grf_mp: stored-value select, optional write-through and busy flag.
// GRF_BYPASS_EN enables same-cycle write forwarding and write-relieved busy.
module grf_bypass_mux
  import grf_mp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic [ADDR_W-1:0]   rd_addr_i,
  input  logic [DATA_W-1:0]   stored_i,
  input  logic [CNT_W-1:0]    cnt_i,
`ifdef GRF_BYPASS_EN
  input  logic [1:0]          wr_en_i,
  input  logic [2*ADDR_W-1:0] wr_addr_i,
  input  logic [2*DATA_W-1:0] wr_data_i,
`endif
  output logic [DATA_W-1:0]   rd_data_o,
  output logic                rd_busy_o
);

  logic rd_nz_s;
  assign rd_nz_s = (rd_addr_i != ADDR_W'(ZERO_REG));

`ifdef GRF_BYPASS_EN
  logic       m0_s;
  logic       m1_s;
  logic [1:0] n_match_s;

  assign m0_s      = wr_en_i[0] && rd_nz_s && (wr_addr_i[0 +: ADDR_W] == rd_addr_i);
  assign m1_s      = wr_en_i[1] && rd_nz_s && (wr_addr_i[ADDR_W +: ADDR_W] == rd_addr_i);
  assign n_match_s = {1'b0, m0_s} + {1'b0, m1_s};

  // Younger write port wins; busy is cleared if matching writes retire every pending count.
  always_comb begin
    rd_data_o = stored_i;
    if (m1_s) begin
      rd_data_o = wr_data_i[DATA_W +: DATA_W];
    end else if (m0_s) begin
      rd_data_o = wr_data_i[0 +: DATA_W];
    end else begin
      rd_data_o = stored_i;
    end
    rd_busy_o = rd_nz_s && ((CNT_W+2)'(cnt_i) > (CNT_W+2)'(n_match_s));
  end
`else
  assign rd_data_o = stored_i;
  assign rd_busy_o = rd_nz_s && (cnt_i != '0);
`endif

endmodule

// File: rtl/grf_mp.sv
// Multi-port GRF: NREAD combinational reads, two prioritised writes, pending-write scoreboard.
// Optional write-through bypass selected with the GRF_BYPASS_EN macro.
module grf_mp
  import grf_mp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREAD  = 2,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NREAD*ADDR_W-1:0] rd_addr_i,
  output logic [NREAD*DATA_W-1:0] rd_data_o,
  output logic [NREAD-1:0]        rd_busy_o,
  input  logic [1:0]              wr_en_i,
  input  logic [2*ADDR_W-1:0]     wr_addr_i,
  input  logic [2*DATA_W-1:0]     wr_data_i,
  input  logic                    iss_en_i,
  input  logic [ADDR_W-1:0]       iss_addr_i,
  output logic                    iss_full_o,
  output logic                    pend_any_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0]       mem_q   [DEPTH];
  logic [DATA_W-1:0]       mem_d   [DEPTH];
  logic [CNT_W-1:0]        cnt_q   [DEPTH];
  logic [CNT_W-1:0]        cnt_d   [DEPTH];
  logic signed [CNT_W+1:0] cnt_sum [DEPTH];

  logic [ADDR_W-1:0] wa0_s, wa1_s;
  logic              we0_s, we1_s, iss_ok_s;

  assign wa0_s    = wr_addr_i[0 +: ADDR_W];
  assign wa1_s    = wr_addr_i[ADDR_W +: ADDR_W];
  assign we0_s    = wr_en_i[0] && (wa0_s != ADDR_W'(ZERO_REG));
  assign we1_s    = wr_en_i[1] && (wa1_s != ADDR_W'(ZERO_REG));
  assign iss_ok_s = iss_en_i && (iss_addr_i != ADDR_W'(ZERO_REG));

  // Next-state storage and counters; port 1 applied last so it wins on address collision.
  always_comb begin
    mem_d      = mem_q;
    iss_full_o = iss_ok_s && (cnt_q[iss_addr_i] == CNT_MAX);
    pend_any_o = 1'b0;
    if (we0_s) begin
      mem_d[wa0_s] = wr_data_i[0 +: DATA_W];
    end else begin
      mem_d[wa0_s] = mem_q[wa0_s];
    end
    if (we1_s) begin
      mem_d[wa1_s] = wr_data_i[DATA_W +: DATA_W];
    end else begin
      mem_d[wa1_s] = mem_d[wa1_s];
    end
    for (int i = 0; i < DEPTH; i++) begin
      cnt_sum[i] = $signed({2'b00, cnt_q[i]})
                 + (CNT_W+2)'(net_delta(
                     iss_ok_s && (iss_addr_i == ADDR_W'(i)) && (cnt_q[i] != CNT_MAX),
                     {1'b0, we0_s && (wa0_s == ADDR_W'(i))} +
                     {1'b0, we1_s && (wa1_s == ADDR_W'(i))}));
      if (cnt_sum[i] < $signed((CNT_W+2)'(0))) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_sum[i][CNT_W-1:0];
      end
      pend_any_o = pend_any_o | (cnt_q[i] != '0);
    end
  end

  // State registers; reset wipes data and pending counts immediately.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra_s;
    assign ra_s = rd_addr_i[k*ADDR_W +: ADDR_W];

    grf_bypass_mux #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
    ) u_mux (
      .rd_addr_i (ra_s),
      .stored_i  (mem_q[ra_s]),
      .cnt_i     (cnt_q[ra_s]),
`ifdef GRF_BYPASS_EN
      .wr_en_i   (wr_en_i),
      .wr_addr_i (wr_addr_i),
      .wr_data_i (wr_data_i),
`endif
      .rd_data_o (rd_data_o[k*DATA_W +: DATA_W]),
      .rd_busy_o (rd_busy_o[k])
    );
  end

endmodule

// File: tb/tb_grf_mp.sv
// Scoreboard bench for grf_mp: driver pushes model predictions, monitor pops and compares.
// Model follows the GRF_BYPASS_EN macro the same way the design does.
module tb_grf_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int CMAX = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic [1:0]       wr_en = 2'b00;
  logic [2*AW-1:0]  wr_addr = '0;
  logic [2*DW-1:0]  wr_data = '0;
  logic             iss_en = 1'b0;
  logic [AW-1:0]    iss_addr = '0;
  logic             iss_full;
  logic             pend_any;

  grf_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .CNT_W(2)) dut (
    .clk_i(clk), .reset_i(reset),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .iss_en_i(iss_en), .iss_addr_i(iss_addr),
    .iss_full_o(iss_full), .pend_any_o(pend_any)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NR*DW-1:0] d;
    logic [NR-1:0]    busy;
    logic             full;
    logic             pend;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] m_reg [32];
  int            m_cnt [32];

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = '0;
      m_cnt[i] = 0;
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    int a, hits;
    e.pend = 1'b0;
    for (int i = 0; i < 32; i++) if (m_cnt[i] > 0) e.pend = 1'b1;
    e.full = iss_en && (iss_addr != 0) && (m_cnt[iss_addr] == CMAX);
    for (int k = 0; k < NR; k++) begin
      a = int'(rd_addr[k*AW +: AW]);
      e.d[k*DW +: DW] = m_reg[a];
      hits = 0;
`ifdef GRF_BYPASS_EN
      if (a != 0 && wr_en[0] && int'(wr_addr[0 +: AW]) == a) begin
        e.d[k*DW +: DW] = wr_data[0 +: DW];
        hits++;
      end
      if (a != 0 && wr_en[1] && int'(wr_addr[AW +: AW]) == a) begin
        e.d[k*DW +: DW] = wr_data[DW +: DW];
        hits++;
      end
`endif
      e.busy[k] = (a != 0) && (m_cnt[a] - hits > 0);
    end
    return e;
  endfunction

  task automatic model_step();
    int a0, a1, ia;
    a0 = int'(wr_addr[0 +: AW]);
    a1 = int'(wr_addr[AW +: AW]);
    ia = int'(iss_addr);
    if (iss_en && ia != 0 && m_cnt[ia] < CMAX) m_cnt[ia]++;
    if (wr_en[0] && a0 != 0) begin
      m_reg[a0] = wr_data[0 +: DW];
      m_cnt[a0]--;
    end
    if (wr_en[1] && a1 != 0) begin
      m_reg[a1] = wr_data[DW +: DW];
      m_cnt[a1]--;
    end
    for (int i = 0; i < 32; i++) if (m_cnt[i] < 0) m_cnt[i] = 0;
  endtask

  task automatic drive(input logic [1:0] we, input int wa0, input int wa1,
                       input logic [DW-1:0] wd0, input logic [DW-1:0] wd1,
                       input logic ie, input int ia, input int ra0, input int ra1);
    @(negedge clk);
    reset   = 1'b0;
    wr_en   = we;
    wr_addr = {AW'(wa1), AW'(wa0)};
    wr_data = {wd1, wd0};
    iss_en  = ie;
    iss_addr = AW'(ia);
    rd_addr = {AW'(ra1), AW'(ra0)};
    exp_q.push_back(predict());
    model_step();
  endtask

  task automatic idle_read(input int ra0, input int ra1);
    drive(2'b00, 0, 0, '0, '0, 1'b0, 0, ra0, ra1);
  endtask

  task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle, sampled 2 time units after the drive edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int k = 0; k < NR; k++) begin
          cmp($sformatf("rd_data[%0d]", k), rd_data[k*DW +: DW], e.d[k*DW +: DW]);
          cmp($sformatf("rd_busy[%0d]", k), 32'(rd_busy[k]), 32'(e.busy[k]));
        end
        cmp("iss_full", 32'(iss_full), 32'(e.full));
        cmp("pend_any", 32'(pend_any), 32'(e.pend));
      end
    end
  end

  initial begin
    int guard;
    model_clear();
    repeat (2) @(posedge clk);

    // Every address on both ports reads zero after reset.
    for (int i = 0; i < 16; i++) idle_read(i, 31 - i);

    // Same-address dual write: port 1 wins, visible now (bypass) and next cycle.
    drive(2'b11, 5, 5, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 0, 5, 5);
    idle_read(5, 0);

    // Register 0 ignores writes and issues.
    drive(2'b11, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 0, 0);
    idle_read(0, 0);

    // Saturate addr 7, then drain with three writes.
    for (int i = 0; i < 4; i++) drive(2'b00, 0, 0, '0, '0, 1'b1, 7, 7, 0);
    for (int i = 0; i < 3; i++) drive(2'b01, 7, 0, 32'(i + 100), '0, 1'b0, 0, 7, 7);
    idle_read(7, 7);

    // Issue plus write on a counter of 1 leaves it at 1.
    drive(2'b00, 0, 0, '0, '0, 1'b1, 9, 9, 0);
    drive(2'b01, 9, 0, 32'h0000_0909, '0, 1'b1, 9, 0, 0);
    idle_read(9, 9);

    // Issue plus two writes on a counter of 1 goes to 0.
    drive(2'b11, 9, 9, 32'h1, 32'h2, 1'b1, 9, 9, 9);
    idle_read(9, 9);

    // Randomised traffic over a small address range to force collisions.
    for (int n = 0; n < 400; n++) begin
      drive(2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 7));
    end

    // Asynchronous reset between edges clears busy and pend_any immediately.
    drive(2'b00, 0, 0, '0, '0, 1'b1, 3, 3, 3);
    drive(2'b00, 0, 0, '0, '0, 1'b1, 3, 3, 3);
    @(negedge clk);
    wr_en = 2'b00;
    iss_en = 1'b0;
    rd_addr = {AW'(3), AW'(3)};
    #1;
    reset = 1'b1;
    model_clear();
    exp_q.push_back(predict());
    for (int i = 0; i < 4; i++) idle_read(3, 5);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #5;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/grf_mp.md
# grf_mp

Parametrised multi-port general register file for the pipelined MIPS core, generalising the single-write GRF. It provides NREAD combinational read ports, two prioritised write ports, optional write-through bypass, and a per-register pending-write scoreboard. The decode stage uses the scoreboard for stall decisions. The block sits between decode (reads, issue) and writeback (writes).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NREAD, 2, number of read ports (1..4)
- CNT_W, 2, width of per-register pending counter
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all registers and counters immediately
- rd_addr  in  NREAD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
- rd_data  out  NREAD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
- rd_busy  out  NREAD  port k register has an unresolved pending write
- wr_en  in  2  write enables; bit 1 = younger instruction
- wr_addr  in  2*ADDR_W  write addresses
- wr_data  in  2*DATA_W  write data
- iss_en  in  1  issue of instruction that will write iss_addr
- iss_addr  in  ADDR_W  destination register being issued
- iss_full  out  1  counter for iss_addr at max; issue this cycle is dropped
- pend_any  out  1  OR of all pending counters non-zero

## Operation
- Register 0:
  - Reads 0.
  - Writes to it are ignored.
  - Its counter is never incremented.
- Write:
  - On posedge, each enabled port with addr != 0 stores its data.
  - If both ports target the same address, port 1 data wins.
- Read (combinational), with bypass compiled in:
  - If a read address matches an enabled non-zero write address, rd_data returns that write's data.
  - If both write ports match, port 1 data is returned.
  - Otherwise rd_data returns the stored value.
- Pending counter per register, updated on posedge:
  - +1 when iss_en and iss_addr != 0 and the counter is not at max.
  - −1 for each enabled write port to that address, saturating at 0.
  - Underflow is not an error: untracked writes are allowed.
- Net update:
  - Issue and one write to the same register in the same cycle leave the counter unchanged.
  - Issue plus two writes gives −1.
- iss_full:
  - Asserts when iss_en, iss_addr != 0 and the counter equals 2**CNT_W−1.
  - The increment is suppressed; the caller must stall and retry.
- rd_busy[k], with bypass compiled in:
  - Asserts when counter(rd_addr[k]) != 0.
  - It does not assert when the enabled writes this cycle that match rd_addr[k] would bring the counter to 0; the bypassed value is then final.
  - rd_busy[k] is always 0 for address 0.

## Timing
- Read latency 0 cycles; write latency 1 cycle (visible from the stored array on the next cycle).
- Issue is visible in rd_busy the cycle after iss_en.
- Reset values:
  - rd_data is 0 for all addresses.
  - rd_busy = 0, iss_full = 0, pend_any = 0.
  - Counters are 0.
- Reset asserted mid-operation discards all pending counts and stored data asynchronously. Writes and issues in the cycle reset deasserts take effect on the first posedge after deassertion.

## Configuration
- GRF_BYPASS_EN:
  - Defined: write-through bypass and the bypass-aware rd_busy as described.
  - Undefined: rd_data always returns stored array contents; rd_busy = counter != 0, with no same-cycle write relief. The decode stage stalls one extra cycle on RAW hazards.

## Structure
- Shared package holds:
  - DATA_W/ADDR_W defaults
  - ZERO_REG constant
  - pending-counter type
  - helper function computing the net counter delta from (issue, write-match count)
- Sub-module grf_bypass_mux: one read port's bypass and priority select, instantiated NREAD times via generate.

## Test plan
- Reset, then read every address on all ports → 0; rd_busy = 0; pend_any = 0.
- Write port 0 addr 5 = 0x1234_5678 and port 1 addr 5 = 0xDEAD_BEEF in the same cycle, read addr 5 same cycle and next → 0xDEAD_BEEF both times (bypass build); next cycle only (non-bypass build).
- Write addr 0 = 0xFFFF_FFFF with iss_en addr 0 → rd_data 0, rd_busy 0, pend_any 0.
- Issue addr 7 three times (CNT_W=2) then a fourth time → iss_full = 1 on the fourth, counter 3. Three writes to addr 7 → rd_busy clears in the cycle of the third write (bypass build) or one cycle later (non-bypass build).
- Same cycle iss_en addr 9 and wr_en[0] addr 9 with counter 1 → counter stays 1, rd_busy stays 1.
- Issue addr 3 twice, assert reset asynchronously between edges → rd_busy and pend_any drop immediately without a clock edge.
